// File: rtl/int_block_multiplier.sv
// Integer DIM x DIM block multiplier: captures A and B via strobes, computes C = A x B
// with one shared MAC (k innermost, then n, then m), and holds C until acknowledged.
module int_block_multiplier #(
    parameter int WIDTH = 32,
    parameter int DIM   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     A_stb,
    input  logic                     B_stb,
    input  logic [WIDTH*DIM*DIM-1:0] A,
    input  logic [WIDTH*DIM*DIM-1:0] B,
    input  logic                     result_ack,
    output logic                     result_ready,
    output logic [WIDTH*DIM*DIM-1:0] result,
    output logic                     busy
);
    localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIM - 1);
    localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t                   state_reg;
    logic [WIDTH*DIM*DIM-1:0] a_reg;
    logic [WIDTH*DIM*DIM-1:0] b_reg;
    logic                     a_got_reg;
    logic                     b_got_reg;
    logic [WIDTH-1:0]         acc_reg;
    logic [IDX_W-1:0]         m_reg;
    logic [IDX_W-1:0]         n_reg;
    logic [IDX_W-1:0]         k_reg;
    logic                     result_ready_reg;
    logic [WIDTH-1:0]         res_reg [DIM][DIM];

    logic [WIDTH-1:0]         a_elem [DIM][DIM];
    logic [WIDTH-1:0]         b_elem [DIM][DIM];
    logic [WIDTH-1:0]         a_op;
    logic [WIDTH-1:0]         b_op;
    logic [WIDTH-1:0]         prod_lo;
    logic [WIDTH-1:0]         mac_sum;

    generate
        for (genvar gi = 0; gi < DIM * DIM; gi++) begin : g_elem
            assign a_elem[gi / DIM][gi % DIM]   = a_reg[gi*WIDTH +: WIDTH];
            assign b_elem[gi / DIM][gi % DIM]   = b_reg[gi*WIDTH +: WIDTH];
            assign result[gi*WIDTH +: WIDTH]    = res_reg[gi / DIM][gi % DIM];
        end
    endgenerate

    // The low WIDTH bits of a two's-complement product do not depend on operand
    // signedness, so a WIDTH-wide multiply gives the truncated signed result directly.
    assign a_op    = a_elem[m_reg][k_reg];
    assign b_op    = b_elem[k_reg][n_reg];
    assign prod_lo = a_op * b_op;
    assign mac_sum = acc_reg + prod_lo;

    assign result_ready = result_ready_reg;
    assign busy         = (state_reg != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= S_IDLE;
            a_reg            <= '0;
            b_reg            <= '0;
            a_got_reg        <= 1'b0;
            b_got_reg        <= 1'b0;
            acc_reg          <= '0;
            m_reg            <= '0;
            n_reg            <= '0;
            k_reg            <= '0;
            result_ready_reg <= 1'b0;
            for (int i = 0; i < DIM; i++) begin
                for (int j = 0; j < DIM; j++) begin
                    res_reg[i][j] <= '0;
                end
            end
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (A_stb && !a_got_reg) begin
                        a_reg     <= A;
                        a_got_reg <= 1'b1;
                    end
                    if (B_stb && !b_got_reg) begin
                        b_reg     <= B;
                        b_got_reg <= 1'b1;
                    end
                    if ((a_got_reg || A_stb) && (b_got_reg || B_stb)) begin
                        state_reg <= S_CALC;
                        acc_reg   <= '0;
                        m_reg     <= '0;
                        n_reg     <= '0;
                        k_reg     <= '0;
                    end
                end
                S_CALC: begin
                    if (k_reg == LAST) begin
                        res_reg[m_reg][n_reg] <= mac_sum;
                        acc_reg               <= '0;
                        k_reg                 <= '0;
                        if (n_reg == LAST) begin
                            n_reg <= '0;
                            if (m_reg == LAST) begin
                                result_ready_reg <= 1'b1;
                                state_reg        <= S_DONE;
                            end else begin
                                m_reg <= m_reg + ONE;
                            end
                        end else begin
                            n_reg <= n_reg + ONE;
                        end
                    end else begin
                        acc_reg <= mac_sum;
                        k_reg   <= k_reg + ONE;
                    end
                end
                S_DONE: begin
                    if (result_ack) begin
                        result_ready_reg <= 1'b0;
                        a_got_reg        <= 1'b0;
                        b_got_reg        <= 1'b0;
                        state_reg        <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_int_block_multiplier.sv
// Directed bench for int_block_multiplier: table of operand/expected blocks plus
// hand-written sequences for staggering, ignored inputs, reset and back-to-back use.
module tb_int_block_multiplier;
    localparam int WIDTH = 32;
    localparam int DIM   = 4;
    localparam int NB    = WIDTH * DIM * DIM;
    typedef logic [NB-1:0] blk_t;

    typedef struct {
        string name;
        blk_t  a;
        blk_t  b;
        blk_t  exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, A_stb, B_stb, result_ack, result_ready, busy;
    blk_t A, B, result;

    int n_vec = 0;
    int n_bad = 0;

    int_block_multiplier #(.WIDTH(WIDTH), .DIM(DIM)) dut (
        .clk(clk), .reset(reset), .A_stb(A_stb), .B_stb(B_stb), .A(A), .B(B),
        .result_ack(result_ack), .result_ready(result_ready), .result(result), .busy(busy)
    );

    function automatic blk_t fill(input logic [31:0] v);
        blk_t r;
        for (int i = 0; i < DIM * DIM; i++) r[i*WIDTH +: WIDTH] = v;
        return r;
    endfunction

    function automatic blk_t diag(input logic [31:0] v);
        blk_t r = '0;
        for (int i = 0; i < DIM; i++) r[(DIM*i+i)*WIDTH +: WIDTH] = v;
        return r;
    endfunction

    // B[m][n] = 4m+n+1
    function automatic blk_t bseq();
        blk_t r;
        for (int m = 0; m < DIM; m++)
            for (int n = 0; n < DIM; n++) r[(DIM*m+n)*WIDTH +: WIDTH] = 32'(4*m + n + 1);
        return r;
    endfunction

    // all-ones A times bseq: C[m][n] = sum_k (4k+n+1) = 28 + 4n
    function automatic blk_t colsum();
        blk_t r;
        for (int m = 0; m < DIM; m++)
            for (int n = 0; n < DIM; n++) r[(DIM*m+n)*WIDTH +: WIDTH] = 32'(28 + 4*n);
        return r;
    endfunction

    task automatic check_blk(input string name, input blk_t act, input blk_t exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end else $display("ok   %s", name);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end else $display("ok   %s = %0d", name, act);
    endtask

    // Called at the negedge right after a capture edge; counts edges until result_ready.
    task automatic wait_ready(output int edges);
        edges = 0;
        while (result_ready !== 1'b1 && edges < 200) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic launch(input string name, input blk_t a, input blk_t b);
        A = a; B = b; A_stb = 1'b1; B_stb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        A_stb = 1'b0; B_stb = 1'b0;
        check_int({name, " busy after capture"}, int'(busy), 1);
    endtask

    task automatic finish_op(input string name, input blk_t exp, input int ack_delay);
        int e;
        wait_ready(e);
        check_int({name, " latency"}, e, 64);
        check_blk({name, " result"}, result, exp);
        repeat (ack_delay) @(negedge clk);
        check_int({name, " ready held"}, int'(result_ready), 1);
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        check_int({name, " ready after ack"}, int'(result_ready), 0);
        check_int({name, " busy after ack"}, int'(busy), 0);
    endtask

    vec_t vecs[6];

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, stale;
        vecs[0] = '{"identity",   diag(32'd1),         bseq(),              bseq()};
        vecs[1] = '{"neg_wrap",   fill(32'hFFFFFFFF),  fill(32'd3),         fill(32'hFFFFFFF4)};
        vecs[2] = '{"pow2_wrap",  fill(32'h40000000),  fill(32'h40000000),  fill(32'h00000000)};
        vecs[3] = '{"twoI_x5",    diag(32'd2),         fill(32'd5),         fill(32'd10)};
        vecs[4] = '{"ones_x_seq", fill(32'd1),         bseq(),              colsum()};
        vecs[5] = '{"max_x2",     fill(32'h7FFFFFFF),  fill(32'd2),         fill(32'hFFFFFFF8)};

        reset = 1'b0; A_stb = 1'b0; B_stb = 1'b0; result_ack = 1'b0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        check_int("reset ready", int'(result_ready), 0);
        check_int("reset busy", int'(busy), 0);
        check_blk("reset result", result, '0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            launch(vecs[i].name, vecs[i].a, vecs[i].b);
            finish_op(vecs[i].name, vecs[i].exp, 3);
        end

        // Staggered operands; A bus corrupted after capture.
        A = fill(32'd1); B = '0; A_stb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        A_stb = 1'b0;
        repeat (2) @(negedge clk);
        A = fill(32'hDEADBEEF);
        repeat (4) @(negedge clk);
        check_int("stagger busy before B", int'(busy), 0);
        B = bseq(); B_stb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        B_stb = 1'b0;
        finish_op("stagger", colsum(), 1);

        // Inputs toggled during S_CALC must be ignored.
        launch("ignore", diag(32'd2), fill(32'd5));
        for (int c = 0; c < 20; c++) begin
            result_ack = (c == 5);
            if (c >= 8 && c < 13) begin
                A_stb = 1'b1; B_stb = 1'b1; A = fill(32'h12345678); B = fill(32'h9ABCDEF0);
            end else begin
                A_stb = 1'b0; B_stb = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        result_ack = 1'b0;
        check_int("ignore busy mid", int'(busy), 1);
        wait_ready(e);
        check_int("ignore latency", e + 20, 64);
        check_blk("ignore result", result, fill(32'd10));
        result_ack = 1'b1;
        @(negedge clk);
        check_int("held ack ready", int'(result_ready), 0);
        repeat (3) @(negedge clk);
        check_int("held ack busy", int'(busy), 0);
        check_int("held ack ready later", int'(result_ready), 0);
        result_ack = 1'b0;
        @(negedge clk);

        // Reset in the middle of a computation.
        launch("midreset", fill(32'd1), bseq());
        repeat (30) @(negedge clk);
        reset = 1'b0;
        #1;
        check_int("midreset ready", int'(result_ready), 0);
        check_int("midreset busy", int'(busy), 0);
        check_blk("midreset result", result, '0);
        @(negedge clk);
        reset = 1'b1;
        stale = 0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (result_ready !== 1'b0 || busy !== 1'b0) stale++;
        end
        check_int("midreset no stale", stale, 0);
        launch("after_reset", diag(32'd2), fill(32'd5));
        finish_op("after_reset", fill(32'd10), 0);

        // Back-to-back: new pair strobed the cycle after ack.
        launch("b2b_first", diag(32'd1), bseq());
        wait_ready(e);
        check_blk("b2b_first result", result, bseq());
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        check_int("b2b_first ready after ack", int'(result_ready), 0);
        launch("b2b_second", fill(32'hFFFFFFFF), fill(32'd3));
        finish_op("b2b_second", fill(32'hFFFFFFF4), 0);

        // Strobes held through ack are recaptured as a new operand pair.
        A = fill(32'd1); B = bseq(); A_stb = 1'b1; B_stb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wait_ready(e);
        check_blk("held_stb result", result, colsum());
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        check_int("held_stb ready after ack", int'(result_ready), 0);
        check_int("held_stb busy after ack", int'(busy), 0);
        @(negedge clk);
        check_int("held_stb recaptured", int'(busy), 1);
        A_stb = 1'b0; B_stb = 1'b0; A = fill(32'hDEADBEEF);
        finish_op("held_stb second", colsum(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
